// File: rtl/button_debouncer.sv
// Push-button conditioner: polarity normalisation, 2-flop synchroniser and a
// four-state debounce FSM producing a clean level plus press/release strobes.
module button_debouncer #(
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_HIGH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic                 ACT_INV  = (BTN_ACTIVE_HIGH == 0);

    logic                 act;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 btn_level_q, btn_level_d;
    logic                 btn_press_q, btn_press_d;
    logic                 btn_release_q, btn_release_d;

    // Normalise to 1 = pressed before crossing into the clk domain.
    assign act = push_button ^ ACT_INV;

    always_comb begin
        sync1_d = act;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            btn_level_q   <= 1'b0;
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_level_q   <= btn_level_d;
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
        end
    end

    // The counter is cleared on every state change, so the terminal compare
    // at DEBOUNCE_CYCLES-1 is always reached before the counter could wrap.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        btn_level_d   = btn_level_q;
        btn_press_d   = 1'b0;
        btn_release_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                btn_level_d = 1'b0;
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                btn_level_d = 1'b0;
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    btn_level_d = 1'b1;
                    btn_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            HELD: begin
                btn_level_d = 1'b1;
                if (!sync2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                btn_level_d = 1'b1;
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    btn_level_d   = 1'b0;
                    btn_release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                btn_level_d = 1'b0;
            end
        endcase
    end

    assign btn_level   = btn_level_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;

endmodule
